timer_counter: RTL
==================

Name: timer_counter

Overview:
Memory-mapped programmable down-counter peripheral on the CPU's data bus bridge. Software programs a preset and a mode through three word registers. The block counts down and raises an interrupt request on expiry. Its irq output drives one HWInt line into the CP0 interrupt logic, where it appears in Cause.IP and is gated by SR.IM, SR.IE and SR.EXL.

Parameters:
- CNT_W, 32, width of PRESET and COUNT.
- CTRL_W, 4, number of implemented CTRL bits. Upper CTRL bits read as 0.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  2  word offset within the block: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- we  input  1  bus write strobe for this block, valid for one cycle.
- din  input  32  bus write data.
- dout  output  32  read data. Combinational from addr. Reserved offset reads 0.
- irq  output  1  interrupt request to CP0 HWInt.

Behaviour:
Registers:
- CTRL[0] EN: count enable.
- CTRL[2:1] MODE:
  - 00 one-shot.
  - 01 auto-reload.
  - 10 and 11 behave as 00.
- CTRL[3] IM: interrupt mask; 1 = irq may assert.
- PRESET: reload value.
- COUNT: current value, read-only; writes to offset 2 are ignored.
- irq = CTRL[3] & irq_flag. irq_flag is an internal register.

Reset (asynchronous, takes effect immediately):
- state=IDLE; CTRL=0; PRESET=0; COUNT=0; irq_flag=0.
- irq=0.
- dout follows addr: reads 0 at every offset.

Bus writes:
- When we=1 the write is performed and the FSM holds that cycle: no state change, no count update.
- Write to CTRL: CTRL <= din[3:0], zero-extended. Also clears irq_flag; this is the software acknowledge.
- Write to PRESET: PRESET <= din. It affects only the next LOAD. An in-progress count is unaffected.

FSM (advances only on cycles with we=0):
- IDLE:
  - if EN: go to LOAD, irq_flag <= 0.
  - else stay; COUNT holds.
- LOAD: COUNT <= PRESET; go to CNT.
- CNT:
  - if !EN: go to IDLE; COUNT holds its current value.
  - else if COUNT > 1: COUNT <= COUNT - 1.
  - else (COUNT is 1 or 0): COUNT <= 0; irq_flag <= 1; go to INT.
- INT:
  - MODE 01: irq_flag <= 0; go to IDLE. EN stays 1, so the counter reloads automatically.
  - otherwise: CTRL[0] <= 0; go to IDLE. irq_flag stays 1 until a CTRL write or the next enable.

Timing:
- With PRESET=P≥1, written enable at edge E0 and no further writes: LOAD at E1; COUNT=P at E2; COUNT reaches 0 and irq asserts at E2+P.
- PRESET=0 behaves like P=1: INT at E3.
- Auto-reload: irq is a 1-cycle pulse with period P+3 cycles.
- Decrement never wraps below 0.

Boundary conditions:
- Write of EN=0 during CNT: the next we=0 cycle enters IDLE. COUNT is frozen and readable.
- A later re-enable reloads from PRESET; there is no resume.
- Write coinciding with the INT cycle: the write wins. INT is processed on the next we=0 cycle. irq_flag is cleared only if the write targets CTRL.
- IM=0: irq_flag still sets internally. Setting IM later exposes a pending one-shot irq.
- Back-to-back writes stall the FSM indefinitely. This is intended.

Decomposition:
- Shared package timer_pkg:
  - state encoding (IDLE, LOAD, CNT, INT), 2 bits.
  - offsets CTRL_OFF=0, PRESET_OFF=1, COUNT_OFF=2.
  - mode codes MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01.
  - CTRL bit indices EN_BIT=0, MODE_LSB=1, IM_BIT=3.
- No sub-module is needed. Register file, FSM and read mux live in a single module.

Test Plan:
- Reset asserted asynchronously mid-CNT with COUNT=3 -> immediately irq=0, state IDLE, all reads at offsets 0/1/2 return 0.
- Write PRESET=5, then CTRL=4'b1001 at E0 -> COUNT reads 5,4,3,2,1,0 at E2..E7; irq=1 from E7; CTRL reads 0x8; irq stays high until CTRL is written with 0x8, then irq=0 the next cycle.
- PRESET=2, CTRL=4'b1011 (auto-reload) -> irq high exactly one cycle, repeating every 5 cycles; CTRL stays 0xB.
- PRESET=10, enable with IM=1; after COUNT=6, write CTRL=0x8 -> COUNT freezes at its value in the next cycle (6 or 5 per the hold rule); no irq; writing CTRL=0x9 restarts from 10.
- PRESET=0, CTRL=0x9 -> irq at E3. Writing PRESET=7 during CNT does not change the current run. Writing offset 2 leaves COUNT unchanged; offset 3 reads 0.
- IM=0, one-shot PRESET=1 expires -> irq=0; then write CTRL=0x8 -> irq stays 0 because the CTRL write cleared irq_flag.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counter peripheral:
// FSM states, register offsets, mode codes and CTRL bit positions.
package timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_e;

    localparam logic [1:0] CTRL_OFF   = 2'd0;
    localparam logic [1:0] PRESET_OFF = 2'd1;
    localparam logic [1:0] COUNT_OFF  = 2'd2;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam int unsigned EN_BIT   = 0;
    localparam int unsigned MODE_LSB = 1;
    localparam int unsigned IM_BIT   = 3;

endpackage

// File: rtl/timer_counter.sv
// Programmable down-counter with one-shot / auto-reload modes and a maskable
// interrupt request; register file, FSM and read mux in one module.
module timer_counter
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    state_e             state_q, state_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               irq_flag_q, irq_flag_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // A bus write consumes the cycle: the FSM and counter hold while it lands.
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        if (we) begin
            case (addr)
                CTRL_OFF: begin
                    ctrl_d     = din[CTRL_W-1:0];
                    irq_flag_d = 1'b0;
                end
                PRESET_OFF: preset_d = din[CNT_W-1:0];
                default: ;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ctrl_q[EN_BIT]) begin
                        state_d    = S_LOAD;
                        irq_flag_d = 1'b0;
                    end
                end
                S_LOAD: begin
                    count_d = preset_q;
                    state_d = S_CNT;
                end
                S_CNT: begin
                    if (!ctrl_q[EN_BIT]) begin
                        state_d = S_IDLE;
                    end else if (count_q > CNT_W'(1)) begin
                        count_d = count_q - CNT_W'(1);
                    end else begin
                        count_d    = '0;
                        irq_flag_d = 1'b1;
                        state_d    = S_INT;
                    end
                end
                S_INT: begin
                    if (ctrl_q[MODE_LSB +: 2] == MODE_RELOAD) begin
                        irq_flag_d = 1'b0;
                    end else begin
                        ctrl_d[EN_BIT] = 1'b0;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            CTRL_OFF:   dout = 32'(ctrl_q);
            PRESET_OFF: dout = 32'(preset_q);
            COUNT_OFF:  dout = 32'(count_q);
            default:    dout = '0;
        endcase
    end

    assign irq = ctrl_q[IM_BIT] & irq_flag_q;

endmodule
